// File: rtl/man_alu_pkg.sv
// Shared types and constants for the pipelined mantissa adder/subtractor.
package man_alu_pkg;

  localparam logic OP_ADD = 1'b0;
  localparam logic OP_SUB = 1'b1;

  localparam int SIZE_MAN_DEF  = 28;
  localparam int NUM_STAGE_DEF = 2;

  typedef struct packed {
    logic vld;
    logic eff_sub;
    logic carry;
  } stg_ctl_t;

  function automatic logic eff_sub_f(
    input logic op,
    input logic smax,
    input logic smin
  );
    return (op == OP_SUB) ^ smax ^ smin;
  endfunction

endpackage

// File: rtl/man_alu_seg.sv
// One adder segment of the mantissa pipeline.
module man_alu_seg #(
  parameter int W = 14
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  assign {o_cout, o_sum} = {1'b0, i_a}
                         + {1'b0, i_b}
                         + {{W{1'b0}}, i_cin};

endmodule

// File: rtl/man_alu_pipe.sv
// Segmented, stallable mantissa add/sub pipeline.
// Optional o_zero output: define MAN_ALU_PIPE_ZERO_DET_EN.
module man_alu_pipe
  import man_alu_pkg::*;
#(
  parameter int SIZE_MAN  = SIZE_MAN_DEF,
  parameter int NUM_OP    = 1,
  parameter int NUM_STAGE = NUM_STAGE_DEF
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_flush,
  input  logic                i_valid,
  output logic                o_ready,
  input  logic [NUM_OP-1:0]   i_fpu_op,
  input  logic                i_sign_max,
  input  logic                i_sign_min,
  input  logic [SIZE_MAN-1:0] i_man_max,
  input  logic [SIZE_MAN-1:0] i_man_min,
  output logic                o_valid,
  input  logic                i_ready,
  output logic [SIZE_MAN-1:0] o_man_alu,
  output logic                o_overflow,
  output logic                o_eff_sub
`ifdef MAN_ALU_PIPE_ZERO_DET_EN
  ,
  output logic                o_zero
`endif
);

  localparam int SEG = SIZE_MAN / NUM_STAGE;

  logic w_adv;
  logic w_eff;

  assign w_eff = eff_sub_f(i_fpu_op[0], i_sign_max, i_sign_min);
  assign w_adv = ~o_valid | i_ready;
  assign o_ready = w_adv;

  for (genvar k = 0; k < NUM_STAGE; k++) begin : g_stg
    localparam int IW = SIZE_MAN - k * SEG;
    localparam int OW = (k + 1) * SEG;

    logic [IW-1:0]  w_a;
    logic [IW-1:0]  w_b;
    logic           w_cin;
    logic           w_es;
    logic           w_vld;
    logic [SEG-1:0] w_s;
    logic           w_co;
    logic [OW-1:0]  w_sum;

    stg_ctl_t       r_ctl;
    logic [OW-1:0]  r_sum;

    if (k == 0) begin : g_head
      assign w_a   = i_man_max;
      assign w_b   = w_eff ? ~i_man_min : i_man_min;
      assign w_cin = w_eff;
      assign w_es  = w_eff;
      assign w_vld = i_valid;
      assign w_sum = w_s;
    end else begin : g_body
      // Upper operand bits arrive pre-shifted: this segment sits at bit 0.
      assign w_a   = g_stg[k-1].g_fwd.r_a;
      assign w_b   = g_stg[k-1].g_fwd.r_b;
      assign w_cin = g_stg[k-1].r_ctl.carry;
      assign w_es  = g_stg[k-1].r_ctl.eff_sub;
      assign w_vld = g_stg[k-1].r_ctl.vld;
      assign w_sum = {w_s, g_stg[k-1].r_sum};
    end

    man_alu_seg #(
      .W(SEG)
    ) u_seg (
      .i_a   (w_a[SEG-1:0]),
      .i_b   (w_b[SEG-1:0]),
      .i_cin (w_cin),
      .o_sum (w_s),
      .o_cout(w_co)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
        r_ctl <= '0;
        r_sum <= '0;
      end else if (w_adv) begin
        r_ctl <= '{vld: w_vld & ~i_flush,
                   eff_sub: w_es,
                   carry: w_co};
        r_sum <= w_sum;
      end else if (i_flush) begin
        r_ctl.vld <= 1'b0;
      end
    end

    if (k < NUM_STAGE - 1) begin : g_fwd
      logic [IW-SEG-1:0] r_a;
      logic [IW-SEG-1:0] r_b;

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          r_a <= '0;
          r_b <= '0;
        end else if (w_adv) begin
          r_a <= w_a[IW-1:SEG];
          r_b <= w_b[IW-1:SEG];
        end
      end
    end
  end

  assign o_valid    = g_stg[NUM_STAGE-1].r_ctl.vld;
  assign o_man_alu  = g_stg[NUM_STAGE-1].r_sum;
  assign o_eff_sub  = g_stg[NUM_STAGE-1].r_ctl.eff_sub;
  assign o_overflow = g_stg[NUM_STAGE-1].r_ctl.carry
                    & ~g_stg[NUM_STAGE-1].r_ctl.eff_sub;

`ifdef MAN_ALU_PIPE_ZERO_DET_EN
  logic r_zero;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_zero <= 1'b0;
    end else if (w_adv) begin
      r_zero <= (g_stg[NUM_STAGE-1].w_sum == '0);
    end
  end

  assign o_zero = r_zero;
`endif

endmodule
